// File: rtl/adc_cfg_pkg.sv
// Shared definitions for the ADC configuration SPI master: FSM encoding,
// default frame geometry and command-word field positions.
package adc_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    localparam int unsigned FRAME_BITS_DEF = 32;
    localparam int unsigned DATA_BITS_DEF  = 16;

    // Command word layout (cfg_dat)
    localparam int unsigned CMD_BITS = 32;
    localparam int unsigned RW_BIT   = 31;
    localparam int unsigned ADDR_MSB = 30;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned DATA_MSB = 15;
    localparam int unsigned DATA_LSB = 0;

endpackage

// File: rtl/adc_cfg_spi_half_tick.sv
// Half-period tick generator: counts 0..CLK_DIV-1 while enabled and pulses
// tick on the last count; held at zero while disabled.
module spi_half_tick #(
    parameter int unsigned CLK_DIV = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Wrapping half-period counter, parked at zero when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/adc_cfg_spi.sv
// SPI mode-0 master for ADC register configuration. A rising edge on cfg_en
// sends cfg_dat MSB-first; on reads the tail of the frame is captured into
// cfg_rdata. All outputs are registered.
module adc_cfg_spi
    import adc_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 12,
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 lb_clk,
    input  logic                 lb_reset,
    input  logic [31:0]          cfg_dat,
    input  logic                 cfg_en,
    output logic [DATA_BITS-1:0] cfg_rdata,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    output logic                 spi_csn,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int unsigned BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    state_e               state_q;
    logic                 en_q;
    logic                 armed_q;   // cfg_en seen low since reset
    logic [CMD_BITS-1:0]  shreg_q;
    logic [DATA_BITS-1:0] cap_q;
    logic                 rw_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 tick;
    logic                 start;

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk  (lb_clk),
        .rst  (lb_reset),
        .en   (state_q != StIdle),
        .tick (tick)
    );

    // Edge on cfg_en only counts in IDLE; edges during a frame are dropped
    assign start = cfg_en && !en_q && armed_q && (state_q == StIdle);

    // Transaction FSM with shift/capture and registered SPI/status outputs
    always_ff @(posedge lb_clk or posedge lb_reset) begin
        if (lb_reset) begin
            state_q   <= StIdle;
            en_q      <= 1'b0;
            armed_q   <= 1'b0;
            shreg_q   <= '0;
            cap_q     <= '0;
            rw_q      <= 1'b0;
            bit_cnt_q <= '0;
            cfg_rdata <= '0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            spi_csn   <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            en_q     <= cfg_en;
            cfg_done <= 1'b0;
            if (!cfg_en) begin
                armed_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    bit_cnt_q <= '0;
                    if (start) begin
                        state_q  <= StSetup;
                        shreg_q  <= cfg_dat;
                        rw_q     <= cfg_dat[RW_BIT];
                        spi_mosi <= cfg_dat[CMD_BITS-1];
                        spi_csn  <= 1'b0;
                        cfg_busy <= 1'b1;
                    end
                end
                StSetup: begin
                    if (tick) begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (tick) begin
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                            cap_q    <= {cap_q[DATA_BITS-2:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            // Last falling edge ends the frame; no counter overflow
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= StHold;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                shreg_q   <= {shreg_q[CMD_BITS-2:0], 1'b0};
                                spi_mosi  <= shreg_q[CMD_BITS-2];
                            end
                        end
                    end
                end
                StHold: begin
                    if (tick) begin
                        state_q  <= StGap;
                        spi_csn  <= 1'b1;
                        spi_mosi <= 1'b0;
                        if (rw_q) begin
                            cfg_rdata <= cap_q;
                        end
                    end
                end
                StGap: begin
                    if (tick) begin
                        state_q  <= StIdle;
                        cfg_busy <= 1'b0;
                        cfg_done <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_cfg_spi.sv
// Self-checking bench for adc_cfg_spi: a fast instance (CLK_DIV=2) for the
// functional tests and a default instance (CLK_DIV=12) for timing checks.
module tb_adc_cfg_spi;

    localparam int unsigned DIV = 2;
    localparam int unsigned FB  = 32;
    localparam int BUSY_FAST = (FB * 2 + 3) * DIV;
    localparam int BUSY_SLOW = (FB * 2 + 3) * 12;

    logic        lb_clk = 1'b0;
    logic        lb_reset = 1'b1;
    logic [31:0] cfg_dat = '0;
    logic        cfg_en = 1'b0;
    logic [15:0] cfg_rdata;
    logic        cfg_busy, cfg_done, spi_csn, spi_sclk, spi_mosi;
    logic        spi_miso = 1'b0;

    logic        cfg_en2 = 1'b0;
    logic [15:0] s_rdata;
    logic        s_busy, s_done, s_csn, s_sclk, s_mosi;

    int n_checks = 0;
    int n_errors = 0;

    always #10 lb_clk = ~lb_clk;

    adc_cfg_spi #(
        .CLK_DIV    (DIV),
        .FRAME_BITS (FB),
        .DATA_BITS  (16)
    ) dut (
        .lb_clk    (lb_clk),
        .lb_reset  (lb_reset),
        .cfg_dat   (cfg_dat),
        .cfg_en    (cfg_en),
        .cfg_rdata (cfg_rdata),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .spi_csn   (spi_csn),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    adc_cfg_spi dut_slow (
        .lb_clk    (lb_clk),
        .lb_reset  (lb_reset),
        .cfg_dat   (cfg_dat),
        .cfg_en    (cfg_en2),
        .cfg_rdata (s_rdata),
        .cfg_busy  (s_busy),
        .cfg_done  (s_done),
        .spi_csn   (s_csn),
        .spi_sclk  (s_sclk),
        .spi_mosi  (s_mosi),
        .spi_miso  (1'b1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor and ADC model for the fast instance (sole writer of mon_*/miso)
    logic [31:0] adc_word = '0;
    logic [31:0] mon_mosi = '0;
    int          mon_rises = 0;
    int          mon_busy = 0;
    int          mon_done = 0;
    logic        p_sclk = 1'b0;
    logic        p_csn = 1'b1;
    int          adc_idx = 0;

    always @(negedge lb_clk) begin
        if (spi_sclk && !p_sclk) begin
            mon_mosi  <= {mon_mosi[30:0], spi_mosi};
            mon_rises <= mon_rises + 1;
        end
        if (cfg_busy) mon_busy <= mon_busy + 1;
        if (cfg_done) mon_done <= mon_done + 1;
        // ADC shifts out MSB-first, next bit after each falling SCLK
        if (p_csn && !spi_csn) begin
            spi_miso <= adc_word[31];
            adc_idx  <= 30;
        end else if (p_sclk && !spi_sclk && !spi_csn && adc_idx >= 0) begin
            spi_miso <= adc_word[adc_idx];
            adc_idx  <= adc_idx - 1;
        end
        p_sclk <= spi_sclk;
        p_csn  <= spi_csn;
    end

    logic [15:0] exp_rdata = '0;

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge lb_clk);
            if (cfg_done) seen = 1'b1;
        end
        if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    // One full transaction: toggle cfg_en low-high, then compare against the model
    task automatic do_frame(input logic [31:0] cmd, input logic [31:0] adc);
        int b_rise, b_busy, b_done;
        bit seen;
        @(negedge lb_clk);
        cfg_dat  = cmd;
        adc_word = adc;
        cfg_en   = 1'b0;
        @(negedge lb_clk);
        b_rise = mon_rises;
        b_busy = mon_busy;
        b_done = mon_done;
        cfg_en = 1'b1;
        @(negedge lb_clk);
        check_eq("csn_latency", {31'd0, spi_csn}, 32'd0);
        cfg_dat = $urandom();  // must not disturb the running frame
        wait_done(seen);
        if (cmd[31]) exp_rdata = adc[15:0];
        check_eq("mosi_frame", mon_mosi, cmd);
        check_eq("sclk_rises", mon_rises - b_rise, FB);
        check_eq("busy_cycles", mon_busy - b_busy, BUSY_FAST);
        check_eq("rdata_at_done", {16'd0, cfg_rdata}, {16'd0, exp_rdata});
        repeat (3) @(negedge lb_clk);
        check_eq("done_pulses", mon_done - b_done, 32'd1);
        cfg_en = 1'b0;
    endtask

    // Default-divider timing on the second instance (MISO tied high)
    task automatic slow_frame();
        int cyc, t_low, t_r1, t_r2, t_fall, t_high, t_done, n_r, n_busy;
        logic ps;
        bit fin;
        cyc = 0; t_low = -1; t_r1 = -1; t_r2 = -1; t_fall = -1; t_high = -1; t_done = -1;
        n_r = 0; n_busy = 0; ps = 1'b0; fin = 1'b0;
        @(negedge lb_clk);
        cfg_dat = 32'h8055_0000;
        cfg_en2 = 1'b1;
        for (int i = 0; i < 3000 && !fin; i++) begin
            @(negedge lb_clk);
            cyc++;
            if (!s_csn && t_low < 0) t_low = cyc;
            if (s_sclk && !ps) begin
                n_r++;
                if (n_r == 1) t_r1 = cyc;
                if (n_r == 2) t_r2 = cyc;
            end
            if (!s_sclk && ps) t_fall = cyc;
            if (s_csn && t_low >= 0 && t_high < 0) t_high = cyc;
            if (s_busy) n_busy++;
            if (s_done) begin
                fin = 1'b1;
                t_done = cyc;
                check_eq("slow_rdata", {16'd0, s_rdata}, 32'h0000_FFFF);
            end
            ps = s_sclk;
        end
        if (!fin) check_eq("slow_timeout", 32'd0, 32'd1);
        // SETUP half-period plus the initial low half of SCLK
        check_eq("slow_first_rise", t_r1 - t_low, 32'd24);
        check_eq("slow_sclk_period", t_r2 - t_r1, 32'd24);
        check_eq("slow_hold", t_high - t_fall, 32'd12);
        check_eq("slow_gap", t_done - t_high, 32'd12);
        check_eq("slow_busy", n_busy, BUSY_SLOW);
        check_eq("slow_rises", n_r, FB);
        cfg_en2 = 1'b0;
    endtask

    initial begin
        int b_rise, b_busy, b_done;
        bit seen;
        repeat (3) @(negedge lb_clk);
        check_eq("rst_csn", {31'd0, spi_csn}, 32'd1);
        check_eq("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        check_eq("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check_eq("rst_busy", {31'd0, cfg_busy}, 32'd0);
        check_eq("rst_done", {31'd0, cfg_done}, 32'd0);
        check_eq("rst_rdata", {16'd0, cfg_rdata}, 32'd0);
        lb_reset = 1'b0;
        repeat (2) @(negedge lb_clk);

        do_frame(32'h0012_00AB, 32'h1234_5678);   // write: rdata unchanged
        do_frame(32'h8034_0000, 32'h0000_BEEF);   // read
        for (int k = 0; k < 8; k++) begin
            do_frame($urandom(), $urandom());
        end
        slow_frame();

        // Second edge while busy is discarded
        @(negedge lb_clk);
        b_rise = mon_rises;
        b_done = mon_done;
        cfg_en = 1'b1;
        repeat (20) @(negedge lb_clk);
        cfg_en = 1'b0;
        @(negedge lb_clk);
        cfg_en = 1'b1;
        wait_done(seen);
        repeat (BUSY_FAST * 2 + 10) @(negedge lb_clk);
        check_eq("drop_done", mon_done - b_done, 32'd1);
        check_eq("drop_rises", mon_rises - b_rise, FB);
        cfg_en = 1'b0;

        // Reset mid-frame, cfg_en kept high through release
        do_frame(32'h80AA_0000, 32'h0000_C3C3);
        @(negedge lb_clk);
        adc_word = $urandom();
        cfg_dat  = 32'h8001_0000;
        b_rise = mon_rises;
        b_done = mon_done;
        cfg_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge lb_clk);
            if (mon_rises - b_rise == 10 && spi_sclk) seen = 1'b1;
        end
        if (!seen) check_eq("abort_timeout", 32'd0, 32'd1);
        lb_reset = 1'b1;
        #1;
        exp_rdata = '0;
        check_eq("abort_csn", {31'd0, spi_csn}, 32'd1);
        check_eq("abort_sclk", {31'd0, spi_sclk}, 32'd0);
        check_eq("abort_busy", {31'd0, cfg_busy}, 32'd0);
        check_eq("abort_rdata", {16'd0, cfg_rdata}, 32'd0);
        repeat (3) @(negedge lb_clk);
        lb_reset = 1'b0;
        b_busy = mon_busy;
        repeat (300) @(negedge lb_clk);
        check_eq("held_en_busy", mon_busy - b_busy, 32'd0);
        check_eq("abort_no_done", mon_done - b_done, 32'd0);
        do_frame(32'h8077_0000, 32'h0000_5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_cfg_spi.md
ADC_CFG_SPI -- requirements
Module: adc_cfg_spi

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 12, giving lb_clk cycles per SCLK half-period (2 MHz SCLK at 48 MHz); legal range 2..255.
REQ-002 The module SHALL have parameter FRAME_BITS, default 32, giving bits per SPI transaction.
REQ-003 The module SHALL have parameter DATA_BITS, default 16, giving read/write data bits at the frame tail.
REQ-004 lb_clk  input  1  sole clock, 48 MHz local-bus clock.
REQ-005 lb_reset  input  1  reset, asynchronous, active-high.
REQ-006 cfg_dat  input  32  command word from local-bus register 0: [31]=R/W (1=read), [30:16]=address, [15:0]=write data.
REQ-007 cfg_en  input  1  level from local-bus register 1 bit 0; each rising edge requests one transaction.
REQ-008 cfg_rdata  output  16  last read data; looped back to local-bus readback register 0.
REQ-009 cfg_busy  output  1  transaction in progress.
REQ-010 cfg_done  output  1  one-cycle pulse at transaction end.
REQ-011 spi_csn  output  1  ADC chip select, active-low.
REQ-012 spi_sclk  output  1  SPI clock, mode 0 (idle low).
REQ-013 spi_mosi  output  1  serial data to ADC.
REQ-014 spi_miso  input  1  serial data from ADC, synchronous to spi_sclk.

Function
REQ-015 cfg_en SHALL be registered once; the start condition SHALL be cfg_en=1 with its registered copy=0, evaluated in IDLE only.
REQ-016 A rising edge of cfg_en while cfg_busy=1 SHALL be discarded, with no queuing.
REQ-017 On start, cfg_dat SHALL be latched into a shift register; later cfg_dat changes SHALL NOT affect the running frame.
REQ-018 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and GAP: IDLE->SETUP on start, SETUP->SHIFT after one half-period, SHIFT->HOLD after FRAME_BITS SCLK periods, HOLD->GAP after one half-period, GAP->IDLE after one half-period.
REQ-019 spi_csn SHALL be low in SETUP, SHIFT and HOLD, and high otherwise.
REQ-020 spi_sclk SHALL toggle only in SHIFT, starting low, for exactly FRAME_BITS rising edges; it SHALL be low in every other state.
REQ-021 spi_mosi SHALL present the shift-register MSB on entering SETUP and update on each falling spi_sclk; transmission SHALL be MSB-first.
REQ-022 spi_miso SHALL be sampled on each rising spi_sclk; the last DATA_BITS samples SHALL form the read word, MSB first.
REQ-023 On HOLD->GAP, cfg_rdata SHALL be loaded with the read word if R/W=1, and otherwise left unchanged.
REQ-024 cfg_busy SHALL rise the cycle after the start condition and stay high for exactly (FRAME_BITS*2+3)*CLK_DIV cycles.
REQ-025 cfg_done SHALL pulse high for one cycle, in the first cycle cfg_busy is low after a transaction; cfg_rdata SHALL be valid in that cycle.
REQ-026 A half-period tick counter SHALL count 0..CLK_DIV-1 and wrap; it SHALL be held at 0 in IDLE.
REQ-027 A bit counter SHALL count 0..FRAME_BITS-1 without overflow; it SHALL be cleared in IDLE.
REQ-028 If cfg_en rises in the same cycle the FSM returns to IDLE, that edge SHALL be discarded (rule: evaluated in IDLE only).

Reset
REQ-029 When reset is asserted, the module SHALL force, asynchronously: IDLE; spi_csn=1; spi_sclk=0; spi_mosi=0; cfg_busy=0; cfg_done=0; cfg_rdata=0; counters=0; registered cfg_en=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately with spi_csn high, and SHALL NOT update cfg_rdata or pulse cfg_done.
REQ-031 After reset deasserts with cfg_en already high, no transaction SHALL start until cfg_en goes low and then rises again.

Structure
REQ-032 Package adc_cfg_pkg SHALL hold the state encoding, the default FRAME_BITS and DATA_BITS, and the cfg_dat field bit positions (RW_BIT=31, ADDR_MSB/LSB=30/16, DATA_MSB/LSB=15/0).
REQ-033 The design SHALL contain one sub-module, spi_half_tick, that generates the CLK_DIV half-period tick with an enable input.
REQ-034 Top-level logic SHALL consist of the FSM, shift/capture registers and output registers; all outputs SHALL be registered.

Verification
REQ-035 Write: with CLK_DIV=2 and cfg_dat=0x0012_00AB, raise cfg_en -> spi_csn low 1 cycle after the edge; MOSI frame 0x001200AB; 32 rising spi_sclk edges; cfg_busy high for 134 cycles; cfg_done one cycle; cfg_rdata unchanged.
REQ-036 Read: with cfg_dat=0x8034_0000 and the ADC model returning 0xBEEF, raise cfg_en -> cfg_rdata=0xBEEF on the cfg_done cycle; MOSI upper 16 bits 0x8034.
REQ-037 Busy drop: pulse cfg_en low then high at cycle 20 of a running frame -> exactly one frame is generated and a single cfg_done pulse occurs.
REQ-038 Reset abort: assert lb_reset at SCLK edge 10 -> same cycle spi_csn=1, spi_sclk=0, cfg_busy=0, cfg_rdata=0, and no cfg_done pulse.
REQ-039 cfg_en held high: hold cfg_en high through reset release -> no frame; after a low-then-high toggle -> one frame.
REQ-040 Defaults: with CLK_DIV=12, run one read -> spi_sclk period of 24 lb_clk cycles; SETUP, HOLD and GAP of 12 cycles each.
